shift_right_32: RTL and testbench
=================================

// Module: shift_right_32
// PURPOSE
//   Registered 32-bit right shifter for the ALU datapath. Performs logical
//   (SRL/SRLI) or arithmetic (SRA/SRAI) right shift by a 5-bit amount.
//   Built as a 5-stage logarithmic barrel shifter (shifts of 1,2,4,8,16)
//   feeding one output register. Result is valid one clock after sampling.
// PARAMETERS
//   WIDTH    32               data width; only 32 is supported
//   SHAMT_W  $clog2(WIDTH)=5  shift-amount width; derived, never overridden
// PORTS
//   clk        in   1   system clock, rising-edge active
//   rst_n      in   1   asynchronous reset, active low
//   in_valid   in   1   inp/shamt/mode valid this cycle
//   inp        in   32  operand (two's complement when mode=1)
//   shamt      in   5   shift amount, unsigned 0..31
//   mode       in   1   0 = SRL (zero fill), 1 = SRA (sign fill)
//   res        out  32  shifted result (registered)
//   out_valid  out  1   res holds a new result
// BEHAVIOUR
//   - Reset: rst_n low clears res to 32'h0 and out_valid to 0 immediately,
//     independent of clk. They stay cleared while rst_n is low.
//   - Leaving reset: the first capture happens on the first rising clk edge
//     with rst_n high.
//   - Capture: on each rising clk edge with in_valid=1:
//       res <= mode ? ($signed(inp) >>> shamt) : (inp >> shamt)
//       out_valid <= 1
//   - Hold: on each rising clk edge with in_valid=0, res holds its value and
//     out_valid <= 0.
//   - Latency is exactly 1 cycle. Throughput is 1 operation per cycle.
//     There is no backpressure.
//   - Fill bit: fill = mode & inp[31]. Every bit vacated at the MSB end
//     takes the fill value.
//   - Stage k (k=0..4): if shamt[k]=1, shift the previous stage's value
//     right by 2^k and insert fill bits; otherwise pass it through.
//   - shamt is always unsigned. Bit 4 set means a shift of 16 or more,
//     never a negative shift.
//   - shamt=0: res = inp for both modes.
//   - shamt=31, SRL: res = {31'b0, inp[31]}.
//   - shamt=31, SRA: res = all copies of inp[31].
//   - For non-negative inp (inp[31]=0), SRL and SRA give identical results.
//   - Purely combinational from inputs to the register D; no other state.
//     There are no X-propagation dependencies on the previous res.
//   - Reset asserted mid-stream: the in-flight result is discarded and
//     out_valid=0 until the next capture after release.
// TESTING
//   Each vector below is applied with in_valid=1. Check res and out_valid=1
//   on the following edge.
//   1. inp=150, shamt=2: mode=0 -> 37; mode=1 -> 37.
//   2. inp=-13 (0xFFFFFFF3), shamt=3: mode=0 -> 0x1FFFFFFE (536870910);
//      mode=1 -> -2 (0xFFFFFFFE).
//   3. inp=-127 (0xFFFFFF81), shamt=5: mode=0 -> 0x07FFFFFC (134217724);
//      mode=1 -> -4.
//   4. Positives: inp=92, shamt=4 -> 5 for both modes;
//      inp=127, shamt=1 -> 63 for both modes.
//   5. Edges: inp=0x80000000, shamt=31: mode=0 -> 0x00000001;
//      mode=1 -> 0xFFFFFFFF. shamt=0 with any inp -> res=inp.
//   6. Control: assert rst_n=0 mid-stream -> res=0 and out_valid=0 with no
//      clock edge needed. in_valid=0 -> res holds and out_valid=0.
//      Finish with a random sweep of 10k vectors against the >>, >>> model.

Source files
------------

// File: rtl/shift_right_32.sv
// Registered 32-bit logical/arithmetic right shifter: a five-stage logarithmic
// barrel network (1, 2, 4, 8, 16) feeding one output register.
module shift_right_32 #(
    parameter int WIDTH = 32
) (
    input  logic                     clk,
    input  logic                     rst_n,
    input  logic                     in_valid,
    input  logic [WIDTH-1:0]         inp,
    input  logic [$clog2(WIDTH)-1:0] shamt,
    input  logic                     mode,
    output logic [WIDTH-1:0]         res,
    output logic                     out_valid
);

    localparam int SHAMT_W = $clog2(WIDTH);

    logic             fill;
    logic [WIDTH-1:0] stage [0:SHAMT_W];

    // SRA replicates the sign bit; SRL and non-negative operands fill with zero.
    assign fill     = mode & inp[WIDTH-1];
    assign stage[0] = inp;

    generate
        for (genvar gi = 0; gi < SHAMT_W; gi++) begin : g_stage
            localparam int SH = 1 << gi;
            assign stage[gi+1] = shamt[gi] ? {{SH{fill}}, stage[gi][WIDTH-1:SH]}
                                           : stage[gi];
        end
    endgenerate

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            res       <= '0;
            out_valid <= 1'b0;
        end else begin
            out_valid <= in_valid;
            if (in_valid) begin
                res <= stage[SHAMT_W];
            end
        end
    end

endmodule

// File: tb/tb_shift_right_32.sv
// Bench for shift_right_32: literal vectors, reset/hold control checks and a
// randomized sweep compared every cycle against an operator-level model.
module tb_shift_right_32;

    logic        clk;
    logic        rst_n;
    logic        in_valid;
    logic [31:0] inp;
    logic [4:0]  shamt;
    logic        mode;
    logic [31:0] res;
    logic        out_valid;

    int n_cmp = 0;
    int n_bad = 0;

    logic [31:0] m_res;
    logic        m_valid;

    shift_right_32 dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .in_valid  (in_valid),
        .inp       (inp),
        .shamt     (shamt),
        .mode      (mode),
        .res       (res),
        .out_valid (out_valid)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    function automatic logic [31:0] ref_shift(input logic [31:0] x,
                                              input logic [4:0] sh,
                                              input logic m);
        logic signed [31:0] s;
        logic [31:0]        u;
        s = $signed(x) >>> sh;
        u = x >> sh;
        return m ? 32'(s) : u;
    endfunction

    task automatic check(input string name, input logic [31:0] act,
                         input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got 0x%08h expected 0x%08h at %0t", name, act, exp, $time);
        end
    endtask

    // Reference model: async clear, one-cycle capture, hold when idle.
    always @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            m_res   <= 32'h0;
            m_valid <= 1'b0;
        end else begin
            m_valid <= in_valid;
            if (in_valid) m_res <= ref_shift(inp, shamt, mode);
        end
    end

    // Continuous compare, away from the active edge.
    always @(negedge clk) begin
        check("cyc_valid", {31'b0, out_valid}, {31'b0, m_valid});
        check("cyc_res", res, m_res);
    end

    task automatic apply(input string name, input logic [31:0] a,
                         input logic [4:0] sh, input logic m,
                         input logic [31:0] exp);
        @(negedge clk);
        in_valid = 1'b1;
        inp      = a;
        shamt    = sh;
        mode     = m;
        @(posedge clk);
        #1;
        check(name, res, exp);
        check({name, "_v"}, {31'b0, out_valid}, 32'd1);
        $display("vec %-10s inp=0x%08h shamt=%0d mode=%0d res=0x%08h", name, a, sh, m, res);
    endtask

    initial begin
        logic [31:0] r;
        rst_n    = 1'b0;
        in_valid = 1'b0;
        inp      = 32'h0;
        shamt    = 5'd0;
        mode     = 1'b0;
        #12;
        check("rst_res", res, 32'h0);
        check("rst_valid", {31'b0, out_valid}, 32'd0);
        @(negedge clk);
        rst_n = 1'b1;

        apply("v1_srl", 32'd150, 5'd2, 1'b0, 32'd37);
        apply("v1_sra", 32'd150, 5'd2, 1'b1, 32'd37);
        apply("v2_srl", 32'hFFFFFFF3, 5'd3, 1'b0, 32'h1FFFFFFE);
        apply("v2_sra", 32'hFFFFFFF3, 5'd3, 1'b1, 32'hFFFFFFFE);
        apply("v3_srl", 32'hFFFFFF81, 5'd5, 1'b0, 32'h07FFFFFC);
        apply("v3_sra", 32'hFFFFFF81, 5'd5, 1'b1, 32'hFFFFFFFC);
        apply("v4a_srl", 32'd92, 5'd4, 1'b0, 32'd5);
        apply("v4a_sra", 32'd92, 5'd4, 1'b1, 32'd5);
        apply("v4b_srl", 32'd127, 5'd1, 1'b0, 32'd63);
        apply("v4b_sra", 32'd127, 5'd1, 1'b1, 32'd63);
        apply("e31_srl", 32'h80000000, 5'd31, 1'b0, 32'h00000001);
        apply("e31_sra", 32'h80000000, 5'd31, 1'b1, 32'hFFFFFFFF);
        apply("e0_srl", 32'hDEADBEEF, 5'd0, 1'b0, 32'hDEADBEEF);
        apply("e0_sra", 32'h9ABC1234, 5'd0, 1'b1, 32'h9ABC1234);
        apply("e16_sra", 32'h80010000, 5'd16, 1'b1, 32'hFFFF8001);

        // Idle cycle: result holds, valid drops.
        @(negedge clk);
        in_valid = 1'b0;
        inp      = 32'h12345678;
        shamt    = 5'd7;
        @(posedge clk);
        #1;
        check("hold_res", res, 32'hFFFF8001);
        check("hold_valid", {31'b0, out_valid}, 32'd0);
        $display("hold       res=0x%08h out_valid=%0d", res, out_valid);

        // Reset mid-stream, between clock edges.
        apply("pre_rst", 32'hF0F0F0F0, 5'd4, 1'b1, 32'hFF0F0F0F);
        #2;
        rst_n = 1'b0;
        #1;
        check("mid_rst_res", res, 32'h0);
        check("mid_rst_valid", {31'b0, out_valid}, 32'd0);
        $display("mid-reset  res=0x%08h out_valid=%0d", res, out_valid);
        @(negedge clk);
        rst_n = 1'b1;
        apply("post_rst", 32'h00000100, 5'd8, 1'b0, 32'h00000001);

        // Randomized sweep, checked by the per-cycle compare process.
        for (int i = 0; i < 10000; i++) begin
            @(negedge clk);
            in_valid = ($urandom_range(0, 9) < 8);
            r        = $urandom;
            inp      = ($urandom_range(0, 7) == 0) ? {r[31], 31'h0} : r;
            shamt    = 5'($urandom_range(0, 31));
            mode     = 1'($urandom);
        end
        @(negedge clk);
        in_valid = 1'b0;
        @(negedge clk);
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
